fwd_scoreboard: RTL and testbench

- Parametrised successor of the EX-stage forwarding unit.
- Tracks in-flight register writers in a DEPTH-stage slot shift register, so the pipeline no longer routes rd/regwrite per stage.
- Pre-computes forwarding selects for NUM_SRC operands one cycle early (registered, aligned to EX), detects load-use hazards, and handles memory back-pressure and flush.

---
 rtl/fwd_pkg.sv | 25 ++
 rtl/fwd_scoreboard_if.sv | 31 +++
 rtl/fwd_match.sv | 27 ++
 rtl/fwd_scoreboard.sv | 94 +++++++++
 tb/tb_fwd_scoreboard.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard: slot record, select encoding,
// and the select-width helper.
package fwd_pkg;

    localparam int unsigned FW_REG_SRC = 0;
    localparam int unsigned FW_SEL_MEM = 1;
    localparam int unsigned FW_SEL_WB  = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } slot_t;

    // Wide enough for 0 (register file) through DEPTH+1 (retire slot).
    function automatic int unsigned sel_w(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

    function automatic logic is_writer(input slot_t s);
        return s.valid && s.regwrite && (s.rd != 5'd0);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Pipeline-to-scoreboard bundle: ID instruction fields and stall/flush controls in,
// registered EX forwarding selects and load-use status out.
interface fwd_scoreboard_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned CNT_W   = 16
) ();
    localparam int unsigned SEL_W = fwd_pkg::sel_w(DEPTH);

    logic                     id_valid;
    logic [NUM_SRC*5-1:0]     id_rs;
    logic [NUM_SRC-1:0]       id_rs_used;
    logic [4:0]               id_rd;
    logic                     id_regwrite;
    logic                     id_memread;
    logic                     mem_busy;
    logic                     flush;
    logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;
    logic                     load_use_stall;
    logic [CNT_W-1:0]         load_use_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, mem_busy, flush,
        input  ex_fwd_sel, load_use_stall, load_use_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, mem_busy, flush,
        output ex_fwd_sel, load_use_stall, load_use_cnt
    );
endinterface

// File: rtl/fwd_match.sv
// Per-operand priority matcher: picks the youngest in-flight writer of rs as the forward source.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned NSLOT = 2,
    parameter int unsigned SEL_W = 2
) (
    input  logic [4:0]             rs_i,
    input  logic                   used_i,
    input  slot_t [NSLOT-1:0]      slots_i,
    output logic [SEL_W-1:0]       sel_o
);

    always_comb begin
        sel_o = SEL_W'(FW_REG_SRC);
        if (used_i && (rs_i != 5'd0)) begin
            // Scan oldest to youngest so the youngest match is the one left standing.
            for (int j = NSLOT; j >= 1; j--) begin
                if (is_writer(slots_i[j-1]) && (slots_i[j-1].rd == rs_i) &&
                    !((j == 1) && slots_i[0].memread)) begin
                    sel_o = SEL_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: in-flight writer slots, registered EX forward selects, load-use hazard
// detection and stall counter. FWD_RETIRE_EN adds a retire slot searched as select DEPTH+1.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input logic             clk,
    input logic             rst,
    fwd_scoreboard_if.slave sb_if
);

    localparam int unsigned SEL_W = sel_w(DEPTH);
    // Only slots a select can point at are stored; slot DEPTH matters only as the retire source.
`ifdef FWD_RETIRE_EN
    localparam int unsigned NSRCH = DEPTH + 1;
`else
    localparam int unsigned NSRCH = DEPTH;
`endif

    slot_t [NSRCH-1:0]        slots_q, slots_d;
    logic [NUM_SRC*SEL_W-1:0] sel_q, sel_d;
    logic [NUM_SRC*SEL_W-1:0] match_sel;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    slot_t                    id_slot;
    logic                     rs_hit;
    logic                     stall;
    logic                     load_id;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        fwd_match #(
            .NSLOT (NSRCH),
            .SEL_W (SEL_W)
        ) u_match (
            .rs_i    (sb_if.id_rs[5*i +: 5]),
            .used_i  (sb_if.id_rs_used[i]),
            .slots_i (slots_q),
            .sel_o   (match_sel[SEL_W*i +: SEL_W])
        );
    end

    always_comb begin
        id_slot          = '0;
        id_slot.valid    = 1'b1;
        id_slot.rd       = sb_if.id_rd;
        id_slot.regwrite = sb_if.id_regwrite;
        id_slot.memread  = sb_if.id_memread;

        rs_hit = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (sb_if.id_rs_used[i] && (sb_if.id_rs[5*i +: 5] == slots_q[0].rd)) begin
                rs_hit = 1'b1;
            end
        end
        stall   = !sb_if.flush && sb_if.id_valid && is_writer(slots_q[0]) &&
                  slots_q[0].memread && rs_hit;
        load_id = sb_if.id_valid && !sb_if.flush && !stall;
    end

    always_comb begin
        slots_d = slots_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (!sb_if.mem_busy) begin
            for (int k = 1; k < int'(NSRCH); k++) begin
                slots_d[k] = slots_q[k-1];
            end
            slots_d[0] = load_id ? id_slot : slot_t'('0);
            sel_d      = load_id ? match_sel : '0;
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            slots_q <= slots_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sb_if.ex_fwd_sel     = sel_q;
    assign sb_if.load_use_stall = stall;
    assign sb_if.load_use_cnt   = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (NUM_SRC=2, DEPTH=2) with an instruction-history model
// checked every cycle plus hand-computed expectations at key points.
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.NUM_SRC(2), .DEPTH(2), .CNT_W(16)) bus ();

    fwd_scoreboard #(.NUM_SRC(2), .DEPTH(2), .CNT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .sb_if (bus)
    );

`ifdef FWD_RETIRE_EN
    localparam int LIM = 3;
`else
    localparam int LIM = 2;
`endif

    // History of what entered EX, index 0 = instruction currently in EX, 1 = one older, ...
    logic       h_v  [4];
    logic       h_rw [4];
    logic       h_ld [4];
    logic [4:0] h_rd [4];
    logic [3:0] m_sel;
    logic [15:0] m_cnt;
    logic       m_live = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] rs_of(input int i);
        logic [9:0] v;
        v = bus.id_rs;
        return (i == 0) ? v[4:0] : v[9:5];
    endfunction

    function automatic logic m_stall();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2; i++)
            if (bus.id_rs_used[i] && rs_of(i) == h_rd[0]) hit = 1'b1;
        return !bus.flush && bus.id_valid && h_v[0] && h_rw[0] && h_rd[0] != 0 && h_ld[0] && hit;
    endfunction

    // Source of operand i: how many instructions back its youngest producer sits, else 0.
    function automatic logic [3:0] m_next_sel();
        logic [1:0] s [2];
        for (int i = 0; i < 2; i++) begin
            s[i] = 2'd0;
            if (bus.id_rs_used[i] && rs_of(i) != 0) begin
                for (int age = 1; age <= LIM; age++) begin
                    if (s[i] == 0 && h_v[age-1] && h_rw[age-1] && h_rd[age-1] == rs_of(i))
                        s[i] = 2'(age);
                end
            end
        end
        return {s[1], s[0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                h_v[k] <= 1'b0; h_rw[k] <= 1'b0; h_ld[k] <= 1'b0; h_rd[k] <= 5'd0;
            end
            m_sel  <= 4'd0;
            m_cnt  <= 16'd0;
            m_live <= 1'b1;
        end else if (!bus.mem_busy) begin
            automatic logic st = m_stall();
            automatic logic ld = bus.id_valid && !bus.flush && !st;
            for (int k = 1; k < 4; k++) begin
                h_v[k] <= h_v[k-1]; h_rw[k] <= h_rw[k-1];
                h_ld[k] <= h_ld[k-1]; h_rd[k] <= h_rd[k-1];
            end
            h_v[0]  <= ld;
            h_rw[0] <= bus.id_regwrite;
            h_ld[0] <= bus.id_memread;
            h_rd[0] <= bus.id_rd;
            m_sel   <= ld ? m_next_sel() : 4'd0;
            if (st && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_stall", {31'd0, bus.load_use_stall}, {31'd0, m_stall()});
            check("model_sel", {28'd0, bus.ex_fwd_sel}, {28'd0, m_sel});
            check("model_cnt", {16'd0, bus.load_use_cnt}, {16'd0, m_cnt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic instr(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [1:0] used, input logic [4:0] rd, input logic rw,
                         input logic ld);
        bus.id_valid    = v;
        bus.id_rs       = {r2, r1};
        bus.id_rs_used  = used;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = ld;
    endtask

    task automatic nop();
        instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.mem_busy = 1'b0;
        bus.flush    = 1'b0;
        nop();
        tick();
        tick();
        check("rst_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
        check("rst_cnt", {16'd0, bus.load_use_cnt}, 32'h0);
        check("rst_stall", {31'd0, bus.load_use_stall}, 32'h0);
        rst = 1'b0;

        // add x5 ; sub x8, x5, x6
        instr(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0); tick();
        instr(1'b1, 5'd5, 5'd6, 2'b11, 5'd8, 1'b1, 1'b0); #1;
        check("alu_no_stall", {31'd0, bus.load_use_stall}, 32'h0);
        tick();
        check("ex_fwd_mem", {28'd0, bus.ex_fwd_sel}, 32'h1);

        // add x5 ; nop ; or x9, x1, x5
        instr(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0); tick();
        nop(); tick();
        instr(1'b1, 5'd1, 5'd5, 2'b11, 5'd9, 1'b1, 1'b0); tick();
        check("ex_fwd_wb_rs2", {28'd0, bus.ex_fwd_sel}, 32'h8);

        // two writers of x5 in flight: youngest wins
        instr(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0); tick();
        instr(1'b1, 5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0); tick();
        instr(1'b1, 5'd5, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0); tick();
        check("youngest_wins", {28'd0, bus.ex_fwd_sel}, 32'h1);

        // lw x7 ; and x8, x7
        instr(1'b1, 5'd2, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1); tick();
        instr(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0); #1;
        check("lu_stall", {31'd0, bus.load_use_stall}, 32'h1);
        tick();
        check("lu_bubble_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
        check("lu_stall_once", {31'd0, bus.load_use_stall}, 32'h0);
        tick();
        check("lu_sel_wb", {28'd0, bus.ex_fwd_sel}, 32'h2);
        check("lu_cnt", {16'd0, bus.load_use_cnt}, 32'h1);

        // mid-run reset clears everything
        rst = 1'b1; nop(); tick(); rst = 1'b0;
        check("rerst_cnt", {16'd0, bus.load_use_cnt}, 32'h0);
        check("rerst_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);

        // load-use under 3 cycles of memory back-pressure
        instr(1'b1, 5'd2, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1); tick();
        instr(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        bus.mem_busy = 1'b1; #1;
        check("busy_stall", {31'd0, bus.load_use_stall}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("busy_hold_stall", {31'd0, bus.load_use_stall}, 32'h1);
            check("busy_hold_cnt", {16'd0, bus.load_use_cnt}, 32'h0);
        end
        bus.mem_busy = 1'b0;
        tick();
        check("busy_rel_cnt", {16'd0, bus.load_use_cnt}, 32'h1);
        check("busy_rel_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
        tick();
        check("busy_rel_fwd", {28'd0, bus.ex_fwd_sel}, 32'h2);

        // flush coincident with load-use
        instr(1'b1, 5'd2, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1); tick();
        instr(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        bus.flush = 1'b1; #1;
        check("flush_no_stall", {31'd0, bus.load_use_stall}, 32'h0);
        tick();
        bus.flush = 1'b0;
        check("flush_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
        check("flush_cnt", {16'd0, bus.load_use_cnt}, 32'h1);
        #1;
        check("flush_bubble", {31'd0, bus.load_use_stall}, 32'h0);
        tick();
        check("flush_then_wb", {28'd0, bus.ex_fwd_sel}, 32'h2);

        // writer of x0 never forwards
        instr(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0); tick();
        instr(1'b1, 5'd0, 5'd0, 2'b11, 5'd11, 1'b1, 1'b0); tick();
        check("x0_no_fwd", {28'd0, bus.ex_fwd_sel}, 32'h0);

        // x9 written three instructions ahead
        instr(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b1, 1'b0); tick();
        nop(); tick();
        nop(); tick();
        instr(1'b1, 5'd9, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0); tick();
`ifdef FWD_RETIRE_EN
        check("retire_sel", {28'd0, bus.ex_fwd_sel}, 32'h3);
`else
        check("retire_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
`endif
        nop(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
